// File: rtl/sample_ntt_parse.sv
// Purpose: Kyber SampleNTT parser. It rejection-samples 12-bit candidates from SHAKE128 rate blocks into N coefficients below Q.
// Latency: the first candidate is visible the cycle after a block is taken. One candidate is evaluated per cycle with no bubbles inside a block.
// Backpressure: an accepted coefficient holds until coef_ready. Rejects cost one cycle. blk_ready is high only while waiting for a block.
module sample_ntt_parse #(
  parameter int R = 1344,
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         blk_valid,
  input  logic [R-1:0] blk_data,
  output logic         blk_ready,
  output logic         coef_valid,
  output logic [11:0]  coef_data,
  output logic [7:0]   coef_idx,
  input  logic         coef_ready,
  output logic         busy,
  output logic         done,
  output logic [3:0]   blk_count
);

  localparam int CPB = R / 12;
  localparam int CW  = $clog2(CPB);
  localparam int KW  = $clog2(N + 1);
  localparam int IW  = $clog2(R);
  localparam logic [CW-1:0] LAST_CAND  = CW'(CPB - 1);
  localparam logic [KW-1:0] LAST_COUNT = KW'(N - 1);
  localparam logic [11:0]   Q12        = 12'(Q);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_SCAN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [R-1:0]  r_blk;
  logic [CW-1:0] r_cand;
  logic [KW-1:0] r_count;
  logic [3:0]    r_blk_count;

  logic [IW-1:0] w_bit_idx;
  logic [R-1:0]  w_shifted;
  logic [11:0]   w_d;
  logic          w_accept;
  logic          w_last_cand;

  // Candidate c occupies bits [12c+11:12c] of the block.
  // Even candidates are b0 | (b1 & 0xF) << 8. Odd candidates are (b1 >> 4) | b2 << 4.
  assign w_bit_idx   = IW'(r_cand) * IW'(12);
  assign w_shifted   = r_blk >> w_bit_idx;
  assign w_d         = w_shifted[11:0];
  assign w_accept    = (r_state == S_SCAN) && (w_d < Q12);
  assign w_last_cand = (r_cand == LAST_CAND);

  // Coefficient outputs are decoded from registered state and are zero when not valid.
  assign coef_valid = w_accept;
  assign coef_data  = w_accept ? w_d : 12'd0;
  assign coef_idx   = w_accept ? r_count[7:0] : 8'd0;
  assign blk_ready  = (r_state == S_WAIT_BLK);
  assign busy       = (r_state == S_WAIT_BLK) || (r_state == S_SCAN);
  assign done       = (r_state == S_DONE);
  assign blk_count  = r_blk_count;

  // Control FSM: block capture, candidate walk, accepted-count tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_blk       <= '0;
      r_cand      <= '0;
      r_count     <= '0;
      r_blk_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_WAIT_BLK;
            r_cand      <= '0;
            r_count     <= '0;
            r_blk_count <= '0;
          end
        end
        S_WAIT_BLK: begin
          if (blk_valid) begin
            r_blk   <= blk_data;
            r_cand  <= '0;
            r_state <= S_SCAN;
            if (r_blk_count != 4'hF) begin
              r_blk_count <= r_blk_count + 4'd1;
            end
          end
        end
        S_SCAN: begin
          if (w_accept && coef_ready) begin
            r_count <= r_count + KW'(1);
            r_cand  <= r_cand + CW'(1);
            // Reaching N accepted coefficients takes priority and discards the rest of the block.
            if (r_count == LAST_COUNT) begin
              r_state <= S_DONE;
            end else if (w_last_cand) begin
              r_state <= S_WAIT_BLK;
            end
          end else if (!w_accept) begin
            r_cand <= r_cand + CW'(1);
            if (w_last_cand) begin
              r_state <= S_WAIT_BLK;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_ntt_parse.sv
// Directed bench for sample_ntt_parse. Outputs are sampled and inputs are driven on the falling edge.
module tb_sample_ntt_parse;

  logic          clk;
  logic          rst;
  logic          start;
  logic          blk_valid;
  logic [1343:0] blk_data;
  logic          blk_ready;
  logic          coef_valid;
  logic [11:0]   coef_data;
  logic [7:0]    coef_idx;
  logic          coef_ready;
  logic          busy;
  logic          done;
  logic [3:0]    blk_count;

  int checks   = 0;
  int failures = 0;

  sample_ntt_parse #(.R(1344), .Q(3329), .N(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_ready  (blk_ready),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_idx   (coef_idx),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done),
    .blk_count  (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    blk_valid = 1'b0;
    coef_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs one polynomial on all-zero blocks. With bp set, coef_ready follows 1,0,0,1,0,0,...
  task automatic run_zero(input bit bp, output int nx, output int oerr, output int serr,
                          output bit timed_out);
    int         p;
    logic       ready_now;
    logic       prev_stall;
    logic [7:0] pi;
    logic [11:0] pd;
    nx = 0; oerr = 0; serr = 0; timed_out = 1'b1;
    p = 0; prev_stall = 1'b0; pi = '0; pd = '0;
    blk_data = '0;
    blk_valid = 1'b1;
    coef_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (prev_stall && (!coef_valid || coef_idx !== pi || coef_data !== pd)) serr++;
      ready_now = bp ? ((p % 3) == 0) : 1'b1;
      p++;
      coef_ready = ready_now;
      if (coef_valid) begin
        if (coef_data !== 12'd0) oerr++;
        if (ready_now) begin
          if (coef_idx !== nx[7:0]) oerr++;
          nx++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          pi = coef_idx;
          pd = coef_data;
        end
      end
      @(negedge clk);
    end
    blk_valid = 1'b0;
    coef_ready = 1'b1;
  endtask

  initial begin : stim
    int  nx, oerr, serr, k, seen, expi;
    bit  to, found;

    // Reset state
    rst = 1'b0; start = 1'b0; blk_valid = 1'b0; blk_data = '0; coef_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_blk_ready", 32'(blk_ready), 0);
    chk("rst_coef_valid", 32'(coef_valid), 0);
    chk("rst_coef_data", 32'(coef_data), 0);
    chk("rst_coef_idx", 32'(coef_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_blk_count", 32'(blk_count), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_start_busy", 32'(busy), 0);

    // All-zero blocks, always ready
    run_zero(1'b0, nx, oerr, serr, to);
    chk("zero_timeout", 32'(to), 0);
    chk("zero_total", 32'(nx), 256);
    chk("zero_order_errs", 32'(oerr), 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_blk_count", 32'(blk_count), 3);
    chk("zero_busy_after", 32'(busy), 0);

    // All-zero blocks with backpressure, restarted from DONE
    run_zero(1'b1, nx, oerr, serr, to);
    chk("bp_timeout", 32'(to), 0);
    chk("bp_total", 32'(nx), 256);
    chk("bp_order_errs", 32'(oerr), 0);
    chk("bp_stable_errs", 32'(serr), 0);
    chk("bp_done", 32'(done), 1);
    chk("bp_blk_count", 32'(blk_count), 3);

    // Boundary values: 3329 is rejected, then 3328 is accepted, from DONE
    blk_data = '0;
    blk_data[23:0] = 24'hD00D01;
    blk_valid = 1'b1;
    coef_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bnd_wait_ready", 32'(blk_ready), 1);
    chk("bnd_cleared_blk_count", 32'(blk_count), 0);
    @(negedge clk);
    chk("bnd_reject_3329", 32'(coef_valid), 0);
    chk("bnd_busy", 32'(busy), 1);
    chk("bnd_blk_count", 32'(blk_count), 1);
    @(negedge clk);
    chk("bnd_acc_valid", 32'(coef_valid), 1);
    chk("bnd_acc_data", 32'(coef_data), 3328);
    chk("bnd_acc_idx", 32'(coef_idx), 0);
    @(negedge clk);
    chk("bnd_next_valid", 32'(coef_valid), 1);
    chk("bnd_next_data", 32'(coef_data), 0);
    chk("bnd_next_idx", 32'(coef_idx), 1);
    do_reset();

    // All-0xFF block: every candidate rejected
    blk_data = '1;
    blk_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ff_wait_ready", 32'(blk_ready), 1);
    @(negedge clk);
    blk_valid = 1'b0;
    chk("ff_scan_ready", 32'(blk_ready), 0);
    seen = 0;
    if (coef_valid) seen++;
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (coef_valid) seen++;
      if (blk_ready) begin
        k = c;
        break;
      end
    end
    chk("ff_ready_after", 32'(k), 112);
    chk("ff_no_valid", 32'(seen), 0);
    chk("ff_blk_count", 32'(blk_count), 1);
    do_reset();

    // Reset in mid-scan at count 50
    blk_data = '0;
    blk_valid = 1'b1;
    coef_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (coef_valid && coef_idx == 8'd50) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reached_50", 32'(found), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_coef_valid", 32'(coef_valid), 0);
    chk("mid_coef_data", 32'(coef_data), 0);
    chk("mid_coef_idx", 32'(coef_idx), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_blk_ready", 32'(blk_ready), 0);
    chk("mid_blk_count", 32'(blk_count), 0);
    rst = 1'b1;
    blk_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_blk_ready", 32'(blk_ready), 1);
    chk("restart_blk_count", 32'(blk_count), 0);
    blk_valid = 1'b1;
    @(negedge clk);
    chk("restart_valid", 32'(coef_valid), 1);
    chk("restart_idx", 32'(coef_idx), 0);
    chk("restart_blk_count1", 32'(blk_count), 1);
    do_reset();

    // Ignored start and blk_valid during SCAN
    blk_data = '0;
    blk_valid = 1'b1;
    coef_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    expi = 0;
    oerr = 0;
    for (int c = 0; c < 400; c++) begin
      start = 1'b0;
      if (coef_valid) begin
        if (coef_idx !== expi[7:0]) oerr++;
        expi++;
        if (coef_idx == 8'd10) start = 1'b1;
        if (coef_idx == 8'd11) begin
          chk("ign_scan_blk_ready", 32'(blk_ready), 0);
          chk("ign_scan_blk_count", 32'(blk_count), 1);
          chk("ign_scan_busy", 32'(busy), 1);
          blk_data = '0;
          blk_data[7:0] = 8'h05;
        end
        if (coef_idx == 8'd112) begin
          chk("ign_blk2_data", 32'(coef_data), 5);
          chk("ign_blk2_count", 32'(blk_count), 2);
          found = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_reached_112", 32'(found), 1);
    chk("ign_order_errs", 32'(oerr), 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
